// File: rtl/serializer_pkg.sv
// Shared types and constants for the word serializer.
package serializer_pkg;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // Bit counter width: ceil(log2(w)), never below 1.
    function automatic int cnt_bits(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < w) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Load/ready word bus plus serial output and framing status.
interface word_serializer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             aa;
    logic             busy;
    logic             last;
    logic [CNT_W-1:0] words_sent;

    modport master (output din, load, input ready, aa, busy, last, words_sent);
    modport slave  (input din, load, output ready, aa, busy, last, words_sent);
endinterface

// File: rtl/word_serializer_hold.sv
// One-word holding register; lets the next word queue behind the one on the wire.
module word_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             i_write,
    input  logic             i_read,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);
    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_read) begin
            r_full <= 1'b0;
        end else if (i_write) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;
endmodule

// File: rtl/word_serializer.sv
// MSB-first parallel-to-serial converter with a one-word skid for gapless streaming.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   CNT_W      = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               rst,
    word_serializer_if.slave   bus
);
    localparam int             BW       = cnt_bits(WIDTH);
    localparam logic [BW-1:0]  LAST_IDX = BW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bitcnt;
    logic [CNT_W-1:0] r_words;

    logic [WIDTH-1:0] w_hold_data;
    logic             w_hold_full;
    logic             w_accept;
    logic             w_last;
    logic             w_hold_wr;
    logic             w_hold_rd;

    assign w_accept  = bus.load && !w_hold_full;
    assign w_last    = (r_state == SHIFT) && (r_bitcnt == '0);
    // Mid-word loads park in the hold; a load on the last bit bypasses it.
    assign w_hold_wr = w_accept && (r_state == SHIFT) && (r_bitcnt != '0);
    assign w_hold_rd = w_last && w_hold_full;

    word_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clock   (clock),
        .rst     (rst),
        .i_write (w_hold_wr),
        .i_read  (w_hold_rd),
        .i_data  (bus.din),
        .o_data  (w_hold_data),
        .o_full  (w_hold_full)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_words  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= bus.din;
                        r_bitcnt <= LAST_IDX;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_bitcnt != '0) begin
                        r_shift  <= r_shift << 1;
                        r_bitcnt <= r_bitcnt - BW'(1);
                    end else begin
                        r_words <= r_words + CNT_W'(1);
                        if (w_hold_full) begin
                            r_shift  <= w_hold_data;
                            r_bitcnt <= LAST_IDX;
                        end else if (bus.load) begin
                            r_shift  <= bus.din;
                            r_bitcnt <= LAST_IDX;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready      = !w_hold_full;
    assign bus.aa         = (r_state == SHIFT) ? r_shift[WIDTH-1] : IDLE_LEVEL;
    assign bus.busy       = (r_state == SHIFT);
    assign bus.last       = w_last;
    assign bus.words_sent = r_words;
endmodule

// File: tb/tb_word_serializer.sv
// Directed bench: scoreboard of expected serial bits checked every cycle.
module tb_word_serializer;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [1:0] q[$];   // {aa, last} expected per busy cycle

    always #5 clock = ~clock;

    word_serializer_if #(.WIDTH(8), .CNT_W(16)) b1 ();
    word_serializer_if #(.WIDTH(8), .CNT_W(2))  b2 ();

    word_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0), .CNT_W(16)) u_dut (
        .clock (clock), .rst (rst), .bus (b1.slave));
    word_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1), .CNT_W(2)) u_dut2 (
        .clock (clock), .rst (rst), .bus (b2.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the top n bits of w, MSB first; bit 0 carries the last flag.
    task automatic push_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) q.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
    endtask

    task automatic check_out();
        logic [1:0] e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("aa",   32'(b1.aa),   32'(e[1]));
            chk("busy", 32'(b1.busy), 32'd1);
            chk("last", 32'(b1.last), 32'(e[0]));
        end else begin
            chk("aa_idle",   32'(b1.aa),   32'd0);
            chk("busy_idle", 32'(b1.busy), 32'd0);
            chk("last_idle", 32'(b1.last), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        check_out();
    endtask

    initial begin
        b1.din = 8'hFF; b1.load = 1'b1;
        b2.din = 8'h00; b2.load = 1'b1;
        // Reset with load held high: load must be dropped.
        tick(); tick();
        chk("rst_ready", 32'(b1.ready), 32'd1);
        chk("rst_words", 32'(b1.words_sent), 32'd0);
        chk("rst_aa2",   32'(b2.aa), 32'd1);
        b1.load = 1'b0; b2.load = 1'b0; rst = 1'b0;
        tick();
        chk("idle_aa2", 32'(b2.aa), 32'd1);

        // Single word
        b1.din = 8'b0110_1100; b1.load = 1'b1; push_bits(8'h6C, 8);
        tick(); b1.load = 1'b0;
        repeat (8) tick();
        chk("single_words", 32'(b1.words_sent), 32'd1);

        // Back-to-back through the hold register
        b1.din = 8'hA5; b1.load = 1'b1; push_bits(8'hA5, 8);
        tick(); b1.load = 1'b0;
        tick(); tick();
        b1.din = 8'h3C; b1.load = 1'b1; push_bits(8'h3C, 8);
        tick(); b1.load = 1'b0;
        chk("b2b_ready_lo", 32'(b1.ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_ready_lo", 32'(b1.ready), 32'd0);
        end
        tick();
        chk("b2b_ready_hi", 32'(b1.ready), 32'd1);
        repeat (8) tick();
        chk("b2b_words", 32'(b1.words_sent), 32'd3);

        // Bypass on the last-bit cycle
        b1.din = 8'hFF; b1.load = 1'b1; push_bits(8'hFF, 8);
        tick(); b1.load = 1'b0;
        repeat (7) tick();
        chk("byp_ready", 32'(b1.ready), 32'd1);
        b1.din = 8'h01; b1.load = 1'b1; push_bits(8'h01, 8);
        tick(); b1.load = 1'b0;
        repeat (8) tick();
        chk("byp_words", 32'(b1.words_sent), 32'd5);

        // Load while hold is full is ignored
        b1.din = 8'h11; b1.load = 1'b1; push_bits(8'h11, 8);
        tick();
        b1.din = 8'h22; push_bits(8'h22, 8);
        tick();
        b1.din = 8'h33;
        repeat (3) tick();
        b1.load = 1'b0;
        repeat (12) tick();
        chk("drop_words", 32'(b1.words_sent), 32'd7);

        // Reset on the 4th bit aborts the word
        b1.din = 8'hF0; b1.load = 1'b1; push_bits(8'hF0, 4);
        tick(); b1.load = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", 32'(b1.ready), 32'd1);
        chk("mid_rst_words", 32'(b1.words_sent), 32'd0);
        rst = 1'b0;
        b1.din = 8'h81; b1.load = 1'b1; push_bits(8'h81, 8);
        tick(); b1.load = 1'b0;
        repeat (8) tick();
        chk("post_rst_words", 32'(b1.words_sent), 32'd1);

        // IDLE_LEVEL=1 and 2-bit counter wrap on the second instance
        for (int k = 0; k < 5; k++) begin
            b2.din = 8'h00; b2.load = 1'b1;
            tick(); b2.load = 1'b0;
            chk("aa2_msb",  32'(b2.aa),   32'd0);
            chk("busy2",    32'(b2.busy), 32'd1);
            repeat (8) tick();
            chk("aa2_idle", 32'(b2.aa),   32'd1);
            if (k == 2) chk("words2_mid", 32'(b2.words_sent), 32'd3);
        end
        chk("words2_wrap", 32'(b2.words_sent), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
